// File: rtl/id_ctrl_pipe.sv
// Control decode for a 4-stage in-order pipeline: ID decode, load-use stall,
// flush bubbles and ID/EX -> EX/MEM -> MEM/WB control staging. Optional CTRL_STATS_EN adds bubble_cnt.
module id_ctrl_pipe #(
  parameter int REGW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [3:0]      opcode,
  input  logic [2:0]      func,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            flush,
  output logic [2:0]      ex_aluop,
  output logic [2:0]      ex_func,
  output logic [REGW-1:0] ex_rt,
  output logic            ex_alu_src,
  output logic            ex_reg_dst,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_mem_to_reg,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic            stall,
  output logic            illegal
`ifdef CTRL_STATS_EN
  ,
  output logic [15:0]     bubble_cnt
`endif
);

  logic [2:0] dec_aluop;
  logic       dec_alu_src;
  logic       dec_reg_dst;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_mem_to_reg;
  logic       dec_reg_write;
  logic       dec_illegal;
  logic       dec_pass_func;

  // ID/EX fields that only feed later stages
  logic       ex_mem_read;
  logic       ex_mem_write;
  logic       ex_mem_to_reg;
  logic       ex_reg_write;
  logic       mem_reg_write;

  logic       hazard;
  logic       bubble;
  logic       illegal_next;

  always_comb begin
    dec_aluop      = 3'b000;
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_illegal    = 1'b0;
    dec_pass_func  = 1'b0;
    case (opcode)
      4'h0: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        dec_pass_func = 1'b1;
      end
      4'h1: begin dec_aluop = 3'b001; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      4'h2: begin dec_aluop = 3'b011; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      4'h3: begin dec_aluop = 3'b100; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      4'h4: begin dec_aluop = 3'b101; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      4'h5: begin
        dec_aluop      = 3'b001;
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
      end
      4'h6: begin dec_aluop = 3'b001; dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
      4'h7: begin dec_aluop = 3'b010; dec_branch = 1'b1; end
      4'h8: dec_jump = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Load in EX whose destination is read by the instruction in ID
  assign hazard = ex_mem_read && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign stall  = in_valid && hazard && !flush;
  assign bubble = flush || stall || !in_valid || dec_illegal;
  // A stalled illegal instruction is re-presented next cycle, so report it only once
  assign illegal_next = in_valid && dec_illegal && !flush && !stall;

  // ID -> EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_aluop      <= '0;
      ex_func       <= '0;
      ex_rt         <= '0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      illegal <= illegal_next;
      if (bubble) begin
        ex_aluop      <= '0;
        ex_func       <= '0;
        ex_rt         <= '0;
        ex_alu_src    <= 1'b0;
        ex_reg_dst    <= 1'b0;
        ex_branch     <= 1'b0;
        ex_jump       <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_reg_write  <= 1'b0;
      end else begin
        ex_aluop      <= dec_aluop;
        ex_func       <= dec_pass_func ? func : 3'b000;
        ex_rt         <= id_rt;
        ex_alu_src    <= dec_alu_src;
        ex_reg_dst    <= dec_reg_dst;
        ex_branch     <= dec_branch;
        ex_jump       <= dec_jump;
        ex_mem_read   <= dec_mem_read;
        ex_mem_write  <= dec_mem_write;
        ex_mem_to_reg <= dec_mem_to_reg;
        ex_reg_write  <= dec_reg_write;
      end
    end
  end

  // EX -> MEM -> WB, free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
    end else begin
      mem_read       <= ex_mem_read;
      mem_write      <= ex_mem_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_reg_write  <= ex_reg_write;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
    end
  end

`ifdef CTRL_STATS_EN
  logic inserted;
  assign inserted = flush || stall || (in_valid && dec_illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (inserted && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe: expected control words are queued as each
// instruction is driven and compared at the ID/EX, EX/MEM and MEM/WB outputs.
module tb_id_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] opcode;
  logic [2:0] func;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       flush;
  logic [2:0] ex_aluop;
  logic [2:0] ex_func;
  logic [2:0] ex_rt;
  logic       ex_alu_src;
  logic       ex_reg_dst;
  logic       ex_branch;
  logic       ex_jump;
  logic       mem_read;
  logic       mem_write;
  logic       mem_mem_to_reg;
  logic       wb_reg_write;
  logic       wb_mem_to_reg;
  logic       stall;
  logic       illegal;
`ifdef CTRL_STATS_EN
  logic [15:0] bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;
  // word layout: {aluop[2:0], func[2:0], rt[2:0], alu_src, reg_dst, branch, jump,
  //               mem_read, mem_write, mem_to_reg, reg_write}
  logic [16:0] sb[$];
  logic [15:0] bc_exp = 16'd0;

  id_ctrl_pipe #(.REGW(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .opcode(opcode),
    .func(func),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .flush(flush),
    .ex_aluop(ex_aluop),
    .ex_func(ex_func),
    .ex_rt(ex_rt),
    .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst),
    .ex_branch(ex_branch),
    .ex_jump(ex_jump),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_mem_to_reg(mem_mem_to_reg),
    .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg),
    .stall(stall),
    .illegal(illegal)
`ifdef CTRL_STATS_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation did not finish");
  end

  function automatic logic [16:0] mk(input logic [2:0] a, input logic [2:0] f,
                                     input logic [2:0] r, input logic [7:0] fl);
    return {a, f, r, fl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_clear();
    sb.delete();
    repeat (3) sb.push_back(17'd0);
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [2:0] fn, input logic [2:0] rs, input logic [2:0] rt,
                      input logic fl, input logic [16:0] e, input logic es, input logic ei);
    logic [16:0] m;
    logic [16:0] w;
    in_valid = v;
    opcode   = op;
    func     = fn;
    id_rs    = rs;
    id_rt    = rt;
    flush    = fl;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    sb.push_back(e);
    if ((fl || es || (v && op >= 4'd9)) && bc_exp != 16'hFFFF) bc_exp++;
    @(posedge clk);
    #1;
    m = sb[sb.size()-2];
    w = sb[sb.size()-3];
    chk({tag, ".ex"}, 32'({ex_aluop, ex_func, ex_rt, ex_alu_src, ex_reg_dst, ex_branch, ex_jump}),
        32'(e[16:4]));
    chk({tag, ".mem"}, 32'({mem_read, mem_write, mem_mem_to_reg}), 32'({m[3], m[2], m[1]}));
    chk({tag, ".wb"}, 32'({wb_reg_write, wb_mem_to_reg}), 32'({w[0], w[1]}));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ei));
`ifdef CTRL_STATS_EN
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(bc_exp));
`endif
    void'(sb.pop_front());
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, 32'({ex_aluop, ex_func, ex_rt, ex_alu_src, ex_reg_dst, ex_branch, ex_jump,
                            mem_read, mem_write, mem_mem_to_reg, wb_reg_write, wb_mem_to_reg,
                            illegal}), 32'd0);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
`ifdef CTRL_STATS_EN
    chk({tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    opcode = 4'd0;
    func = 3'd0;
    id_rs = 3'd0;
    id_rt = 3'd0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    sb_clear();

    // R-type, func passes through; reg_write reaches WB three edges later
    step("rtype", 1, 4'h0, 3'b101, 3'd1, 3'd2, 0, mk(3'b000, 3'b101, 3'd2, 8'b0100_0001), 0, 0);
    step("idle1", 0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 17'd0, 0, 0);
    step("idle2", 0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 17'd0, 0, 0);

    // ALU-immediate, branch, jump, store
    step("addi",  1, 4'h1, 3'd0, 3'd1, 3'd2, 0, mk(3'b001, 3'd0, 3'd2, 8'b1000_0001), 0, 0);
    step("imm2",  1, 4'h2, 3'd0, 3'd1, 3'd4, 0, mk(3'b011, 3'd0, 3'd4, 8'b1000_0001), 0, 0);
    step("imm3",  1, 4'h3, 3'd0, 3'd1, 3'd5, 0, mk(3'b100, 3'd0, 3'd5, 8'b1000_0001), 0, 0);
    step("imm4",  1, 4'h4, 3'd0, 3'd1, 3'd6, 0, mk(3'b101, 3'd0, 3'd6, 8'b1000_0001), 0, 0);
    step("beq",   1, 4'h7, 3'd0, 3'd1, 3'd2, 0, mk(3'b010, 3'd0, 3'd2, 8'b0010_0000), 0, 0);
    step("jump",  1, 4'h8, 3'd0, 3'd0, 3'd0, 0, mk(3'b000, 3'd0, 3'd0, 8'b0001_0000), 0, 0);
    step("store", 1, 4'h6, 3'd0, 3'd1, 3'd2, 0, mk(3'b001, 3'd0, 3'd2, 8'b1000_0100), 0, 0);

    // Load-use on rs: one stall cycle with a bubble, then the addi issues
    step("ld3",    1, 4'h5, 3'd0, 3'd0, 3'd3, 0, mk(3'b001, 3'd0, 3'd3, 8'b1000_1011), 0, 0);
    step("use_rs", 1, 4'h1, 3'd0, 3'd3, 3'd5, 0, 17'd0, 1, 0);
    step("issue",  1, 4'h1, 3'd0, 3'd3, 3'd5, 0, mk(3'b001, 3'd0, 3'd5, 8'b1000_0001), 0, 0);
    // Load-use on rt
    step("ld1",    1, 4'h5, 3'd0, 3'd0, 3'd1, 0, mk(3'b001, 3'd0, 3'd1, 8'b1000_1011), 0, 0);
    step("use_rt", 1, 4'h0, 3'd3, 3'd0, 3'd1, 0, 17'd0, 1, 0);
    // Matching registers but nothing valid in ID: no stall
    step("ld6",    1, 4'h5, 3'd0, 3'd0, 3'd6, 0, mk(3'b001, 3'd0, 3'd6, 8'b1000_1011), 0, 0);
    step("novld",  0, 4'h1, 3'd0, 3'd6, 3'd6, 0, 17'd0, 0, 0);

    // Flush coincident with a load-use hazard: no stall, bubble, EX/MEM still advances
    step("ld3b",   1, 4'h5, 3'd0, 3'd0, 3'd3, 0, mk(3'b001, 3'd0, 3'd3, 8'b1000_1011), 0, 0);
    step("flush",  1, 4'h1, 3'd0, 3'd3, 3'd4, 1, 17'd0, 0, 0);

    // Illegal opcodes
    step("ill_b",   1, 4'hB, 3'd0, 3'd0, 3'd0, 0, 17'd0, 0, 1);
    step("ill_nv",  0, 4'hF, 3'd0, 3'd0, 3'd0, 0, 17'd0, 0, 0);
    step("ill_fl",  1, 4'hC, 3'd0, 3'd0, 3'd0, 1, 17'd0, 0, 0);
    step("ill_9",   1, 4'h9, 3'd0, 3'd0, 3'd0, 0, 17'd0, 0, 1);
    step("after",   1, 4'h0, 3'd7, 3'd2, 3'd3, 0, mk(3'b000, 3'd7, 3'd3, 8'b0100_0001), 0, 0);

    // Three instructions in flight, then asynchronous reset
    step("f1", 1, 4'h1, 3'd0, 3'd1, 3'd2, 0, mk(3'b001, 3'd0, 3'd2, 8'b1000_0001), 0, 0);
    step("f2", 1, 4'h5, 3'd0, 3'd1, 3'd7, 0, mk(3'b001, 3'd0, 3'd7, 8'b1000_1011), 0, 0);
    step("f3", 1, 4'h0, 3'd1, 3'd1, 3'd2, 0, mk(3'b000, 3'd1, 3'd2, 8'b0100_0001), 0, 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    chk_all_zero("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    sb_clear();
    bc_exp = 16'd0;

    // Store after release: mem_write two edges later
    step("st_rel", 1, 4'h6, 3'd0, 3'd1, 3'd2, 0, mk(3'b001, 3'd0, 3'd2, 8'b1000_0100), 0, 0);
    step("st_i1",  0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 17'd0, 0, 0);
    step("st_i2",  0, 4'h0, 3'd0, 3'd0, 3'd0, 0, 17'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ctrl_pipe.md
ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

Interface
REQ-001 SHALL have parameter REGW, default 3, the register-specifier width.
REQ-002 SHALL have port clk, input, 1, the single clock; every flop is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, the ID stage holds a real instruction.
REQ-005 SHALL have port opcode, input, 4, the instruction opcode.
REQ-006 SHALL have port func, input, 3, the R-type function field.
REQ-007 SHALL have ports id_rs and id_rt, input, REGW each, the ID source registers.
REQ-008 SHALL have port flush, input, 1, a taken branch or jump resolved in EX.
REQ-009 SHALL have ports ex_aluop (3), ex_func (3), ex_rt (REGW), ex_alu_src, ex_reg_dst, ex_branch and ex_jump (1 each), outputs, the ID/EX control.
REQ-010 SHALL have ports mem_read, mem_write and mem_mem_to_reg (1 each), outputs, the EX/MEM control.
REQ-011 SHALL have ports wb_reg_write and wb_mem_to_reg (1 each), outputs, the MEM/WB control.
REQ-012 SHALL have ports stall (1, combinational) and illegal (1, registered pulse), outputs.

Function
REQ-013 SHALL decode opcode into a control word consisting of aluop, alu_src, reg_dst, branch, jump, mem_read, mem_write, mem_to_reg and reg_write.
REQ-014 SHALL decode opcode 0000 (R-type) as aluop 000 with reg_dst=1 and reg_write=1, and SHALL pass func through.
REQ-015 SHALL decode opcodes 0001, 0010, 0011 and 0100 (ALU-immediate) as aluop 001, 011, 100 and 101 respectively, with alu_src=1 and reg_write=1.
REQ-016 SHALL decode opcode 0101 (load) as aluop 001 with alu_src, mem_read, mem_to_reg and reg_write all 1.
REQ-017 SHALL decode opcode 0110 (store) as aluop 001 with alu_src=1 and mem_write=1.
REQ-018 SHALL decode opcode 0111 (beq) as aluop 010 with branch=1, and opcode 1000 (jump) as jump=1 with aluop 000.
REQ-019 SHALL treat opcodes 1001-1111 as illegal: the control word becomes a bubble and illegal pulses high for one cycle on the next edge.
REQ-020 SHALL define a bubble as an all-zero control word; ex_func and ex_rt SHALL also be zero in a bubble.
REQ-021 SHALL decode an in_valid=0 cycle as a bubble, with no illegal pulse.
REQ-022 SHALL assert stall combinationally when in_valid=1, the registered ID/EX mem_read=1, and ex_rt equals id_rs or id_rt (load-use hazard).
REQ-023 SHALL load ID/EX with a bubble on any edge where stall=1; the upstream block holds the instruction in ID.
REQ-024 SHALL give flush priority over stall and over decode: ID/EX loads a bubble, stall is forced to 0, and illegal is suppressed.
REQ-025 SHALL advance EX/MEM from ID/EX and MEM/WB from EX/MEM on every edge, unaffected by stall or flush.
REQ-026 SHALL give ID/EX outputs a latency of 1 cycle, EX/MEM outputs 2 cycles and MEM/WB outputs 3 cycles from decode.

Reset
REQ-027 SHALL, while rst_n=0, drive all registered outputs to 0 asynchronously, including illegal and the optional counter.
REQ-028 SHALL discard all in-flight stages on reset asserted mid-operation, and SHALL resume decoding on the first edge after rst_n deasserts.

Configuration
REQ-029 SHALL add, when CTRL_STATS_EN is defined, a 16-bit output bubble_cnt that increments on every edge where stall, flush or illegal inserts a bubble, saturating at 16'hFFFF.
REQ-030 SHALL omit bubble_cnt and its logic entirely when CTRL_STATS_EN is undefined, with all other behaviour identical.

Verification
REQ-031 SHALL cover: opcode 0000 with func 101 -> after 1 cycle ex_aluop=000, ex_func=101, ex_reg_dst=1; after 3 cycles wb_reg_write=1.
REQ-032 SHALL cover: load with rt=3, then addi with rs=3 -> stall=1 for exactly one cycle, ID/EX bubble, and the addi issues on the following cycle.
REQ-033 SHALL cover: flush=1 coincident with a stall condition -> stall=0, ID/EX all zero, EX/MEM still advances.
REQ-034 SHALL cover: opcode 1011 -> illegal=1 for one cycle and ex_* all zero; with CTRL_STATS_EN defined, bubble_cnt increments by 1.
REQ-035 SHALL cover: rst_n pulled low with three valid instructions in flight -> all outputs 0 immediately; a store applied after release -> mem_write=1 two cycles later.
